// File: rtl/qadd_arbiter_pkg.sv
// Shared sizing and types for the round-robin sign-magnitude adder arbiter.
package qadd_arbiter_pkg;
  localparam int QADD_N    = 32;
  localparam int QADD_Q    = 19;
  localparam int QADD_NREQ = 4;
  localparam int SIGN_BIT  = QADD_N - 1;
  localparam int ID_W      = (QADD_NREQ > 1) ? $clog2(QADD_NREQ) : 1;

  typedef logic [QADD_N-1:0] sm_word_t;

  // Requester-index width; a single requester still gets a 1-bit id.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/qadd.sv
// Combinational sign-magnitude adder; reports the magnitude carry so the caller decides saturation.
module qadd
  import qadd_arbiter_pkg::*;
#(
  parameter int Q = QADD_Q,
  parameter int N = QADD_N
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] c,
  output logic         carry
);
  // Q only places the binary point; addition is position-independent.
  if (Q > N - 1) begin : g_q_exceeds_magnitude
  end

  logic         sa, sb;
  logic [N-2:0] ma, mb;
  logic [N-1:0] mag;

  always_comb begin
    sa  = a[N-1];
    sb  = b[N-1];
    ma  = a[N-2:0];
    mb  = b[N-2:0];
    mag = '0;
    c   = '0;
    if (sa == sb) begin
      mag = {1'b0, ma} + {1'b0, mb};
      c   = {sa, mag[N-2:0]};
    end else if (ma >= mb) begin
      mag = {1'b0, ma - mb};
      c   = {sa, mag[N-2:0]};
    end else begin
      mag = {1'b0, mb - ma};
      c   = {sb, mag[N-2:0]};
    end
    carry = mag[N-1];
  end
endmodule

// File: rtl/qadd_arbiter.sv
// Round-robin arbiter sharing one qadd among NREQ requesters, one-deep registered result.
module qadd_arbiter
  import qadd_arbiter_pkg::*;
#(
  parameter int N    = QADD_N,
  parameter int Q    = QADD_Q,
  parameter int NREQ = QADD_NREQ,
  localparam int IDW = id_width(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0][N-1:0]    req_a,
  input  logic [NREQ-1:0][N-1:0]    req_b,
  input  logic [NREQ-1:0]           req_sub,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [N-1:0]              rsp_data,
  output logic                      rsp_ovf
);
  logic [IDW-1:0] ptr, pick_idx, ptr_nxt;
  logic           pick_any, slot_free, grant;
  logic [N-1:0]   op_a, op_b, sum_c, res_data;
  logic           sum_carry, res_ovf;

  assign slot_free = !rsp_valid || rsp_ready;
  assign grant     = pick_any && slot_free && rst_n;

  // Scan offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    logic [IDW:0] j;
    pick_any = 1'b0;
    pick_idx = '0;
    j        = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = {1'b0, ptr} + (IDW+1)'(k);
      if (j >= (IDW+1)'(NREQ)) j = j - (IDW+1)'(NREQ);
      if (req_valid[j[IDW-1:0]]) begin
        pick_any = 1'b1;
        pick_idx = j[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[pick_idx] = 1'b1;
    ptr_nxt = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
  end

  always_comb begin
    op_a        = req_a[pick_idx];
    op_b        = req_b[pick_idx];
    op_b[N-1]   = op_b[N-1] ^ req_sub[pick_idx];
  end

  qadd #(.Q(Q), .N(N)) u_qadd (
    .a     (op_a),
    .b     (op_b),
    .c     (sum_c),
    .carry (sum_carry)
  );

  // Carry only arises with equal signs, so sum_c already carries the operand sign.
  always_comb begin
    res_data = sum_c;
    res_ovf  = 1'b0;
    if (sum_carry) begin
      res_ovf  = 1'b1;
      res_data = {sum_c[N-1], {(N-1){1'b1}}};
    end else if (sum_c[N-2:0] == '0) begin
      res_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_ovf   <= 1'b0;
      ptr       <= '0;
    end else if (grant) begin
      rsp_valid <= 1'b1;
      rsp_data  <= res_data;
      rsp_id    <= pick_idx;
      rsp_ovf   <= res_ovf;
      ptr       <= ptr_nxt;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_qadd_arbiter.sv
// Directed checks of the qadd_arbiter: arithmetic, round-robin order, backpressure and reset.
module tb_qadd_arbiter;
  import qadd_arbiter_pkg::*;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic [QADD_NREQ-1:0]          req_valid, req_ready, req_sub;
  logic [QADD_NREQ-1:0][QADD_N-1:0] req_a, req_b;
  logic                          rsp_valid, rsp_ready, rsp_ovf;
  logic [ID_W-1:0]               rsp_id;
  sm_word_t                      rsp_data;

  int n_cmp = 0;
  int n_bad = 0;

  qadd_arbiter #(.N(QADD_N), .Q(QADD_Q), .NREQ(QADD_NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ovf(rsp_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input sm_word_t a, input sm_word_t b, input logic sub);
    req_a[i] = a; req_b[i] = b; req_sub[i] = sub;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b1; req_valid = 4'b1111;
    req_a = '0; req_b = '0; req_sub = '0;
    tick(); tick();
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'h0) begin n_bad++; $display("FAIL rst_data: got %h want 0", rsp_data); end
    n_cmp++; if (rsp_id !== 2'd0 || rsp_ovf !== 1'b0) begin n_bad++; $display("FAIL rst_id_ovf: got %0d/%b want 0/0", rsp_id, rsp_ovf); end
    req_valid = '0; rst_n = 1'b1;
  endtask

  task automatic test_add();
    do_reset();
    drive(0, 32'h00080000, 32'h00040000, 1'b0);
    req_valid = 4'b0001; #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL add_grant: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid: got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'h000C0000) begin n_bad++; $display("FAIL add_data: got %h want 000c0000", rsp_data); end
    n_cmp++; if (rsp_id !== 2'd0 || rsp_ovf !== 1'b0) begin n_bad++; $display("FAIL add_id_ovf: got %0d/%b want 0/0", rsp_id, rsp_ovf); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid: got %b want 0", rsp_valid); end
  endtask

  task automatic test_sub();
    drive(2, 32'h00040000, 32'h00080000, 1'b1);
    req_valid = 4'b0100; tick();
    n_cmp++; if (rsp_data !== 32'h80040000 || rsp_id !== 2'd2) begin n_bad++; $display("FAIL sub_neg: got %h/%0d want 80040000/2", rsp_data, rsp_id); end
    drive(2, 32'h00080000, 32'h00080000, 1'b1);
    tick();
    n_cmp++; if (rsp_data !== 32'h00000000 || rsp_ovf !== 1'b0) begin n_bad++; $display("FAIL sub_zero: got %h/%b want 00000000/0", rsp_data, rsp_ovf); end
    drive(2, 32'h80080000, 32'h00080000, 1'b0);
    tick();
    n_cmp++; if (rsp_data !== 32'h00000000) begin n_bad++; $display("FAIL add_negzero: got %h want 00000000", rsp_data); end
    req_valid = '0; tick();
  endtask

  task automatic test_ovf();
    drive(1, 32'h7FFFFFFF, 32'h00000001, 1'b0);
    req_valid = 4'b0010; tick();
    n_cmp++; if (rsp_ovf !== 1'b1 || rsp_data !== 32'h7FFFFFFF) begin n_bad++; $display("FAIL ovf_pos: got %b/%h want 1/7fffffff", rsp_ovf, rsp_data); end
    drive(1, 32'hFFFFFFFF, 32'h00000001, 1'b1);
    tick();
    n_cmp++; if (rsp_ovf !== 1'b1 || rsp_data !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL ovf_neg: got %b/%h want 1/ffffffff", rsp_ovf, rsp_data); end
    drive(1, 32'h7FFFFFFF, 32'h00000001, 1'b1);
    tick();
    n_cmp++; if (rsp_ovf !== 1'b0 || rsp_data !== 32'h7FFFFFFE) begin n_bad++; $display("FAIL ovf_none: got %b/%h want 0/7ffffffe", rsp_ovf, rsp_data); end
    req_valid = '0; tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) drive(i, 32'((i + 1) << 19), 32'h00040000, 1'b0);
    req_valid = 4'b1111; #1;
    for (int c = 0; c < 8; c++) begin
      n_cmp++; if (req_ready !== 4'(1 << (c % 4))) begin n_bad++; $display("FAIL rr_grant%0d: got %b want %b", c, req_ready, 4'(1 << (c % 4))); end
      tick();
      exp_d = 32'(((c % 4) + 1) << 19) + 32'h00040000;
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(c % 4) || rsp_data !== exp_d) begin
        n_bad++; $display("FAIL rr_rsp%0d: got v%b id%0d %h want v1 id%0d %h", c, rsp_valid, rsp_id, rsp_data, c % 4, exp_d);
      end
    end
    req_valid = '0; tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(0, 32'h00080000, 32'h00040000, 1'b0);
    drive(1, 32'h00100000, 32'h00080000, 1'b1);
    drive(3, 32'h00080000, 32'h00100000, 1'b0);
    rsp_ready = 1'b0; req_valid = 4'b0001; tick();
    req_valid = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL stall_ready%0d: got %b want 0000", c, req_ready); end
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h000C0000 || rsp_id !== 2'd0 || rsp_ovf !== 1'b0) begin
        n_bad++; $display("FAIL stall_hold%0d: got v%b %h id%0d o%b want v1 000c0000 id0 o0", c, rsp_valid, rsp_data, rsp_id, rsp_ovf);
      end
      tick();
    end
    rsp_ready = 1'b1; #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL release_grant: got %b want 0010", req_ready); end
    tick();
    n_cmp++; if (rsp_id !== 2'd1 || rsp_data !== 32'h00080000) begin n_bad++; $display("FAIL release_rsp1: got %0d/%h want 1/00080000", rsp_id, rsp_data); end
    req_valid = 4'b1000; #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL release_grant2: got %b want 1000", req_ready); end
    tick();
    n_cmp++; if (rsp_id !== 2'd3 || rsp_data !== 32'h00180000) begin n_bad++; $display("FAIL release_rsp3: got %0d/%h want 3/00180000", rsp_id, rsp_data); end
    req_valid = '0; tick();
  endtask

  task automatic test_reset_mid();
    drive(1, 32'h00080000, 32'h00080000, 1'b0);
    drive(0, 32'h00040000, 32'h00040000, 1'b0);
    drive(3, 32'h00040000, 32'h00080000, 1'b0);
    rsp_ready = 1'b0; req_valid = 4'b0010; tick();
    req_valid = 4'b1001;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin n_bad++; $display("FAIL mid_setup: got v%b id%0d want v1 id1", rsp_valid, rsp_id); end
    rst_n = 1'b0; #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 0000", req_ready); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 32'h0) begin n_bad++; $display("FAIL mid_rst_clear: got v%b id%0d %h want v0 id0 0", rsp_valid, rsp_id, rsp_data); end
    rst_n = 1'b1; rsp_ready = 1'b1; #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_first_grant: got %b want 0001", req_ready); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'h00080000) begin n_bad++; $display("FAIL mid_first_rsp: got v%b id%0d %h want v1 id0 00080000", rsp_valid, rsp_id, rsp_data); end
    req_valid = '0; tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ovf();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/qadd_arbiter.md
QADD_ARBITER -- requirements
Module: qadd_arbiter

Interface
REQ-001 Parameter N, default 32, word width of the sign-magnitude operands (bit N-1 is the sign, bits N-2:0 the magnitude).
REQ-002 Parameter Q, default 19, number of fractional bits passed through to the shared qadd instance.
REQ-003 Parameter NREQ, default 4, number of requesters.
REQ-004 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 req_valid  input  NREQ  per-requester operation valid.
REQ-007 req_ready  output  NREQ  per-requester accept (grant); at most one bit is set per cycle.
REQ-008 req_a  input  NREQ*N  operand A of each requester, sign-magnitude, Q-format.
REQ-009 req_b  input  NREQ*N  operand B of each requester, sign-magnitude, Q-format.
REQ-010 req_sub  input  NREQ  per-requester opcode: 0 = A+B, 1 = A-B.
REQ-011 rsp_valid  output  1  result register holds a valid result.
REQ-012 rsp_ready  input  1  consumer accepts the result.
REQ-013 rsp_id  output  clog2(NREQ)  index of the requester that owns the result.
REQ-014 rsp_data  output  N  sign-magnitude result.
REQ-015 rsp_ovf  output  1  magnitude overflow flag for the result.

Function
REQ-016 A transfer occurs on a requester port when req_valid[i] and req_ready[i] are both 1 at a rising edge; a transfer occurs on the response port when rsp_valid and rsp_ready are both 1.
REQ-017 Slot free = !rsp_valid || rsp_ready; grants are issued only while the slot is free.
REQ-018 Arbitration is round-robin: a pointer ptr selects the first valid requester at or after ptr, modulo NREQ, and req_ready is a combinational function of req_valid, ptr and slot-free.
REQ-019 After each grant to index g, ptr becomes (g+1) mod NREQ; ptr is unchanged in cycles with no grant.
REQ-020 The granted operands feed one shared combinational qadd #(Q,N): a = req_a[g], b = req_b[g] with the sign bit inverted when req_sub[g]=1.
REQ-021 Latency: the result, rsp_id = g and rsp_ovf are registered on the grant edge; rsp_valid is asserted the following cycle, giving 1-cycle latency.
REQ-022 rsp_ovf = 1 when the effective signs are equal and the magnitude sum exceeds 2^(N-1)-1; in that case rsp_data magnitude saturates to all ones and keeps the operand sign.
REQ-023 A zero-magnitude result is always emitted with sign 0; negative zero is never output.
REQ-024 Simultaneous drain and grant in one cycle (rsp_valid && rsp_ready, new grant) overwrites the register with no bubble, sustaining 1 op/cycle.
REQ-025 When rsp_valid=1 and rsp_ready=0, all req_ready are 0, and rsp_data, rsp_id and rsp_ovf are held stable.
REQ-026 A requester may drop req_valid without a transfer; no state depends on a request until it is granted.
REQ-027 When no requester is valid and the slot is free, rsp_valid goes 0 on the next edge.

Reset
REQ-028 While rst_n=0 at a rising edge: rsp_valid=0, rsp_data=0, rsp_id=0, rsp_ovf=0, ptr=0.
REQ-029 req_ready is forced to all zeros while rst_n=0.
REQ-030 Reset asserted mid-operation discards any held result, which is not delivered.

Structure
REQ-031 A shared package holds the N/Q defaults, a sign-magnitude word typedef, the sign-bit index constant and the requester-index width.
REQ-032 Exactly one sub-module, qadd, is instantiated; the round-robin picker and the overflow/saturation logic are local to qadd_arbiter.

Verification
REQ-033 Scenario: requester 0 only, A=0x00080000 (1.0), B=0x00040000 (0.5), sub=0 -> one cycle later rsp_data=0x000C0000, rsp_id=0, rsp_ovf=0.
REQ-034 Scenario: A=0x00040000, B=0x00080000, sub=1 -> rsp_data=0x80040000 (-0.5); and A=B=0x00080000, sub=1 -> rsp_data=0x00000000 (no negative zero).
REQ-035 Scenario: all four requesters valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0,... with one rsp_valid per cycle and no bubbles.
REQ-036 Scenario: rsp_ready held 0 for 3 cycles with two requests pending -> req_ready=0 and outputs stable throughout; after release, the two results arrive in round-robin order.
REQ-037 Scenario: A=0x7FFFFFFF, B=0x00000001, sub=0 -> rsp_ovf=1, rsp_data=0x7FFFFFFF; and A=0xFFFFFFFF, B=0x00000001, sub=1 -> rsp_ovf=1, rsp_data=0xFFFFFFFF.
REQ-038 Scenario: rst_n pulled low while rsp_valid=1 and rsp_ready=0 -> next edge rsp_valid=0 and ptr=0; the first post-reset grant goes to the lowest valid index.
